// File: rtl/demux_route_pkg.sv
// Shared types and constants for the demux route controller and its lane counters.
package demux_route_pkg;

  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_BCAST = 2'd2
  } state_e;

  // Matches the decode of the downstream 1x4 demux with its valid input tied high.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
    lane_onehot = NUM_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/lane_sat_counter.sv
// Per-lane delivered-word counter: saturates at all-ones, clear wins over increment.
module lane_sat_counter
  import demux_route_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_route_ctrl.sv
// Routes one word at a time to a 1x4 demux (unicast or sequential broadcast), with a
// per-lane stall timeout that drops the delivery, and saturating per-lane statistics.
module demux_route_ctrl
  import demux_route_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [1:0]             in_dest,
  input  logic                   in_bcast,
  output logic [DATA_W-1:0]      d_out,
  output logic [1:0]             sel,
  output logic [NUM_LANES-1:0]   out_valid,
  input  logic [NUM_LANES-1:0]   out_ready,
  input  logic                   clr_cnt,
  output logic [NUM_LANES*CNT_W-1:0] lane_cnt,
  output logic                   drop_pulse
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                lane_ready;
  logic                deliver;
  logic                timeout_hit;
  logic [NUM_LANES-1:0] cnt_inc;

  assign in_ready   = (state_q == ST_IDLE) && rst_n;
  assign lane_ready = out_ready[sel_q];

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    wait_d      = wait_q;
    deliver     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          sel_d   = in_bcast ? 2'd0 : in_dest;
          wait_d  = '0;
          state_d = in_bcast ? ST_BCAST : ST_SEND;
        end
      end
      ST_SEND, ST_BCAST: begin
        deliver     = lane_ready;
        // A ready lane always wins over an expiring wait.
        timeout_hit = (TIMEOUT > 0) && !lane_ready && (wait_q == WAIT_LIMIT);
        if (deliver || timeout_hit) begin
          wait_d = '0;
          if ((state_q == ST_SEND) || (sel_q == 2'd3)) begin
            state_d = ST_IDLE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= 2'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
    end
  end

  assign d_out      = data_q;
  assign sel        = sel_q;
  assign out_valid  = (state_q != ST_IDLE) ? lane_onehot(sel_q) : '0;
  assign drop_pulse = timeout_hit;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_cnt
      assign cnt_inc[gi] = deliver && (sel_q == 2'(gi));
      lane_sat_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .inc_i (cnt_inc[gi]),
        .cnt_o (lane_cnt[CNT_W*gi +: CNT_W])
      );
    end
  endgenerate

endmodule
